enemy_march_scheduler: RTL

Sequencer for the enemy formation march. Counts frame ticks and, once per step period, issues a one-cycle update strobe to each enemy row in turn, top row first. It owns the 2-bit phase state consumed by the row movers: phases 00 and 11 march left, phases 01 and 10 march right. It sits between the frame timing generator and the per-row enemy move/position registers.

---
 rtl/enemy_pkg.sv | 27 ++
 rtl/march_period_calc.sv | 26 ++
 rtl/enemy_march_scheduler.sv | 132 +++++++++++++
 3 files changed

// File: rtl/enemy_pkg.sv
// Shared types and constants for the enemy march logic: FSM states, phase codes
// and the phase-to-direction mapping used by the row movers.
package enemy_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_SWEEP   = 2'd2,
        ST_ADVANCE = 2'd3
    } marchState_t;

    localparam logic [1:0] PHASE_L0 = 2'b00;
    localparam logic [1:0] PHASE_R0 = 2'b01;
    localparam logic [1:0] PHASE_R1 = 2'b10;
    localparam logic [1:0] PHASE_L1 = 2'b11;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } marchDir_t;

    // Phases 01 and 10 march right, 00 and 11 march left.
    function automatic marchDir_t phaseDir(input logic [1:0] phase);
        return (phase[1] ^ phase[0]) ? DIR_RIGHT : DIR_LEFT;
    endfunction

endpackage

// File: rtl/march_period_calc.sv
// Step period from the live enemy count: half the count, clamped to
// [MIN_STEP_FRAMES, STEP_FRAMES]; zero alive yields period 0 (march stalls).
module march_period_calc #(
    parameter int unsigned STEP_FRAMES     = 16,
    parameter int unsigned MIN_STEP_FRAMES = 2
) (
    input  logic [5:0] aliveCount,
    output logic [5:0] period
);

    logic [5:0] half;

    always_comb begin
        half = {1'b0, aliveCount[5:1]};
        if (aliveCount == '0) begin
            period = '0;
        end else if (half < 6'(MIN_STEP_FRAMES)) begin
            period = 6'(MIN_STEP_FRAMES);
        end else if (half > 6'(STEP_FRAMES)) begin
            period = 6'(STEP_FRAMES);
        end else begin
            period = half;
        end
    end

endmodule

// File: rtl/enemy_march_scheduler.sv
// Enemy formation march sequencer: frame-tick counting, per-row step strobes and
// the 2-bit march phase. Define ENEMY_MARCH_SPEEDUP_EN for alive-count speed-up.
module enemy_march_scheduler
    import enemy_pkg::*;
#(
    parameter int unsigned ROWS            = 5,
    parameter int unsigned STEP_FRAMES     = 16,
    parameter int unsigned STEPS_PER_PHASE = 32,
    parameter int unsigned MIN_STEP_FRAMES = 2
) (
    input  logic            i_Clk,
    input  logic            i_Rst,
    input  logic            i_Enable,
    input  logic            i_FrameTick,
    input  logic [5:0]      i_AliveCount,
    output logic [1:0]      o_PhaseState,
    output logic [ROWS-1:0] o_RowStep,
    output logic            o_StepDone,
    output logic            o_Busy
);

    localparam int unsigned IDX_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned STEP_W = $clog2(STEPS_PER_PHASE);
    localparam logic [IDX_W-1:0]  ROW_LAST  = IDX_W'(ROWS - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEPS_PER_PHASE - 1);

    marchState_t       state, stateNext;
    logic [5:0]        frameCnt, frameCntNext;
    logic [5:0]        period, periodNext, periodNow;
    logic [IDX_W-1:0]  rowIdx, rowIdxNext;
    logic [STEP_W-1:0] stepCnt, stepCntNext;
    logic [1:0]        phase, phaseNext;
    logic [ROWS-1:0]   rowStepNext;
    logic              qualTick;

`ifdef ENEMY_MARCH_SPEEDUP_EN
    march_period_calc #(
        .STEP_FRAMES    (STEP_FRAMES),
        .MIN_STEP_FRAMES(MIN_STEP_FRAMES)
    ) periodCalc (
        .aliveCount(i_AliveCount),
        .period    (periodNow)
    );
`else
    logic unusedAlive;
    assign unusedAlive = ^i_AliveCount;
    assign periodNow   = 6'(STEP_FRAMES);
`endif

    always_comb begin
        stateNext    = state;
        frameCntNext = frameCnt;
        periodNext   = period;
        rowIdxNext   = rowIdx;
        stepCntNext  = stepCnt;
        phaseNext    = phase;
        // A zero period (no enemies alive) never qualifies a tick.
        qualTick     = i_FrameTick && (period != '0) && (frameCnt == period - 6'd1);

        case (state)
            ST_IDLE: begin
                if (i_Enable) begin
                    stateNext    = ST_WAIT;
                    frameCntNext = '0;
                    periodNext   = periodNow;
                end
            end
            ST_WAIT: begin
                if (!i_Enable) begin
                    stateNext = ST_IDLE;
                end else if (qualTick) begin
                    stateNext  = ST_SWEEP;
                    rowIdxNext = '0;
                end else if (i_FrameTick) begin
                    frameCntNext = frameCnt + 6'd1;
                end
            end
            ST_SWEEP: begin
                if (rowIdx == ROW_LAST) begin
                    stateNext = ST_ADVANCE;
                end else begin
                    rowIdxNext = rowIdx + 1'b1;
                end
            end
            ST_ADVANCE: begin
                stateNext    = ST_WAIT;
                frameCntNext = '0;
                periodNext   = periodNow;
                if (stepCnt == STEP_LAST) begin
                    stepCntNext = '0;
                    phaseNext   = phase + 2'd1;
                end else begin
                    stepCntNext = stepCnt + 1'b1;
                end
            end
            default: stateNext = ST_IDLE;
        endcase

        // Strobes are decoded from the next state so they leave a register.
        rowStepNext = '0;
        if (stateNext == ST_SWEEP) begin
            rowStepNext = ROWS'(1) << rowIdxNext;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state      <= ST_IDLE;
            frameCnt   <= '0;
            period     <= '0;
            rowIdx     <= '0;
            stepCnt    <= '0;
            phase      <= PHASE_L0;
            o_RowStep  <= '0;
            o_StepDone <= 1'b0;
            o_Busy     <= 1'b0;
        end else begin
            state      <= stateNext;
            frameCnt   <= frameCntNext;
            period     <= periodNext;
            rowIdx     <= rowIdxNext;
            stepCnt    <= stepCntNext;
            phase      <= phaseNext;
            o_RowStep  <= rowStepNext;
            o_StepDone <= (stateNext == ST_ADVANCE);
            o_Busy     <= (stateNext == ST_SWEEP) || (stateNext == ST_ADVANCE);
        end
    end

    assign o_PhaseState = phase;

endmodule
